// File: rtl/pe_seq_pkg.sv
// Shared state encoding and PE phase codes for the split-nibble PE phase sequencer.
package pe_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        CAP  = 3'd4,
        OUT  = 3'd5
    } state_t;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_LL   = 2'd1;
    localparam logic [1:0] PH_LH   = 2'd2;
    localparam logic [1:0] PH_HL   = 2'd3;

    // The PE phase is a pure function of the state, so it can never skip or repeat.
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            P1:      return PH_LL;
            P2:      return PH_LH;
            P3:      return PH_HL;
            default: return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pe_seq_acc.sv
// Dot-product accumulator, term counter and result register that holds under backpressure.
module pe_seq_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          fast_clk,
    input  logic                          rst,
    input  logic                          add,
    input  logic                          finish,
    input  logic                          out_ready,
    input  logic signed [2*DATA_WIDTH-1:0] product,
    output logic                          out_valid,
    output logic signed [ACC_WIDTH-1:0]   out_data,
    output logic        [CNT_WIDTH-1:0]   out_count
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic        [CNT_WIDTH-1:0] count;
    logic        [CNT_WIDTH-1:0] count_next;

    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [2*DATA_WIDTH-1:0] p);
        return {{(ACC_WIDTH-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
    endfunction

    assign acc_next   = acc + sext(product);
    assign count_next = count + CNT_WIDTH'(1);

    // add only occurs in CAP and draining only in OUT, so the result register never changes while held.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (add) begin
            if (finish) begin
                out_data  <= acc_next;
                out_count <= count_next;
                out_valid <= 1'b1;
                acc       <= '0;
                count     <= '0;
            end else begin
                acc   <= acc_next;
                count <= count_next;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_phase_sequencer.sv
// Steps one split-nibble PE through phases 1-2-3 per operand pair and accumulates the products.
module pe_phase_sequencer
    import pe_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           fast_clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   in_a,
    input  logic signed [DATA_WIDTH-1:0]   in_b,
    input  logic                           in_last,
    output logic signed [DATA_WIDTH-1:0]   pe_a,
    output logic signed [DATA_WIDTH-1:0]   pe_b,
    output logic        [1:0]              pe_phase,
    input  logic signed [2*DATA_WIDTH-1:0] pe_c_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_WIDTH-1:0]    out_data,
    output logic        [CNT_WIDTH-1:0]    out_count
);

    state_t state;
    state_t state_next;
    logic   armed;
    logic   last_flag;
    logic   load;

    assign pe_phase = phase_of(state);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = armed;
                if (in_valid && armed) begin
                    load       = 1'b1;
                    state_next = P1;
                end
            end
            P1:  state_next = P2;
            P2:  state_next = P3;
            P3:  state_next = CAP;
            CAP: begin
                if (last_flag) begin
                    state_next = OUT;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load       = 1'b1;
                        state_next = P1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            OUT: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // armed keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            pe_a      <= '0;
            pe_b      <= '0;
            last_flag <= 1'b0;
        end else if (load) begin
            pe_a      <= in_a;
            pe_b      <= in_b;
            last_flag <= in_last;
        end
    end

    pe_seq_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_acc (
        .fast_clk  (fast_clk),
        .rst       (rst),
        .add       (state == CAP),
        .finish    (last_flag),
        .out_ready (out_ready),
        .product   (pe_c_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count)
    );

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// Bench for pe_phase_sequencer: directed plan plus random dot products against a product-queue model.
module tb_pe_phase_sequencer;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int CW = 8;

    logic                 fast_clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a;
    logic signed [DW-1:0] in_b;
    logic                 in_last;
    logic signed [DW-1:0] pe_a;
    logic signed [DW-1:0] pe_b;
    logic [1:0]           pe_phase;
    logic signed [2*DW-1:0] pe_c_out = '0;
    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_data;
    logic [CW-1:0]        out_count;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int hs_cycle = 0;
    int prods[$];

    pe_phase_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .fast_clk  (fast_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_phase  (pe_phase),
        .pe_c_out  (pe_c_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #2 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cycle <= cycle + 1;

    // Behavioural PE: captures the product on the edge that ends phase 3.
    always @(posedge fast_clk) begin
        if (pe_phase == 2'd3) pe_c_out <= 16'($signed(pe_a) * $signed(pe_b));
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    // Present one pair, then walk it through P1..P3; returns at the CAP sample point.
    task automatic do_term(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b, input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        chk("accept_phase0", {30'b0, pe_phase}, 32'd0);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        tick();
        hs_cycle = cycle;
        prods.push_back(int'(a) * int'(b));
        chk("phase1", {30'b0, pe_phase}, 32'd1);
        chk("pe_a", {24'b0, pe_a}, {24'b0, a});
        chk("pe_b", {24'b0, pe_b}, {24'b0, b});
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
        in_last = 1'($urandom);
        tick();
        chk("phase2", {30'b0, pe_phase}, 32'd2);
        chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
        chk("pe_a_hold", {24'b0, pe_a}, {24'b0, a});
        tick();
        chk("phase3", {30'b0, pe_phase}, 32'd3);
        chk("pe_b_hold", {24'b0, pe_b}, {24'b0, b});
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        tick();
        chk("cap_phase0", {30'b0, pe_phase}, 32'd0);
        chk("cap_in_ready", {31'b0, in_ready}, {31'b0, !last});
        chk("cap_pe_a", {24'b0, pe_a}, {24'b0, a});
    endtask

    // Called at the CAP sample point of a last term; checks result and backpressure hold.
    task automatic finish_dot(input int bp);
        int s = 0;
        logic [AW-1:0] exp_d;
        logic [CW-1:0] exp_c;
        foreach (prods[i]) s += prods[i];
        exp_d = s[AW-1:0];
        exp_c = CW'(prods.size());
        prods.delete();
        out_ready = (bp == 0);
        tick();
        chk("latency", cycle - hs_cycle, 32'd4);
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("out_data", {8'b0, out_data}, {8'b0, exp_d});
        chk("out_count", {24'b0, out_count}, {24'b0, exp_c});
        chk("out_in_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < bp; k++) begin
            tick();
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_data", {8'b0, out_data}, {8'b0, exp_d});
            chk("bp_count", {24'b0, out_count}, {24'b0, exp_c});
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_phase", {30'b0, pe_phase}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int h0;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_phase", {30'b0, pe_phase}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {8'b0, out_data}, 32'd0);
        chk("rst_out_count", {24'b0, out_count}, 32'd0);
        chk("rst_pe_a", {24'b0, pe_a}, 32'd0);
        chk("rst_pe_b", {24'b0, pe_b}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        do_term(8'sd3, 8'sd5, 1'b1);
        finish_dot(0);
        do_term(-8'sd7, 8'sd9, 1'b1);
        finish_dot(0);
        do_term(-8'sd128, -8'sd128, 1'b1);
        finish_dot(5);

        do_term(8'sd10, 8'sd10, 1'b0);
        h0 = hs_cycle;
        do_term(-8'sd20, 8'sd3, 1'b0);
        chk("b2b_gap1", hs_cycle - h0, 32'd4);
        h0 = hs_cycle;
        do_term(8'sd127, 8'sd127, 1'b1);
        chk("b2b_gap2", hs_cycle - h0, 32'd4);
        finish_dot(0);

        do_term(8'sd4, 8'sd4, 1'b0);
        in_valid = 1'b1;
        in_a     = 8'sd5;
        in_b     = 8'sd5;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_phase2", {30'b0, pe_phase}, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("midrst_phase", {30'b0, pe_phase}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        prods.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("after_rst_valid", {31'b0, out_valid}, 32'd0);
            chk("after_rst_phase", {30'b0, pe_phase}, 32'd0);
        end
        do_term(8'sd2, 8'sd2, 1'b1);
        finish_dot(0);

        do_term(8'sd6, 8'sd7, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("gap_in_ready", {31'b0, in_ready}, 32'd1);
            chk("gap_valid", {31'b0, out_valid}, 32'd0);
        end
        do_term(8'sd1, 8'sd1, 1'b1);
        finish_dot(0);

        for (int d = 0; d < 15; d++) begin
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                do_term(8'($urandom), 8'($urandom), i == n - 1);
                if (i != n - 1) repeat ($urandom_range(0, 2)) tick();
            end
            finish_dot(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 600; i++) do_term(-8'sd128, -8'sd128, i == 599);
        finish_dot(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_phase_sequencer.md
Name: pe_phase_sequencer

Overview:
- Drives the 3-phase multiply protocol of one split-nibble PE: presents a signed operand pair, steps phase 1→2→3 on fast_clk, then collects the PE's C_out.
- Accumulates successive products into a dot-product result.
- Returns the result through a valid/ready output port.
- Sits between the operand feeder and a PE_x_00_5-style multiplier.

Parameters:
- DATA_WIDTH, 8, operand width; PE product width is 2*DATA_WIDTH.
- ACC_WIDTH, 24, accumulator/result width; two's-complement wrap-around.
- CNT_WIDTH, 8, term-counter width.

Ports:
- fast_clk  in  1  phase clock (4 ns)
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts operand pair
- in_a  in  DATA_WIDTH  signed multiplicand
- in_b  in  DATA_WIDTH  signed multiplier
- in_last  in  1  pair is final term of the dot product
- pe_a  out  DATA_WIDTH  operand to PE a
- pe_b  out  DATA_WIDTH  operand to PE b
- pe_phase  out  2  to PE counter_for_exact_mult_usage; 0 = idle
- pe_c_out  in  2*DATA_WIDTH  signed PE C_out
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_WIDTH  signed accumulated sum
- out_count  out  CNT_WIDTH  number of terms in out_data

Behaviour:
- Reset (asynchronous) sets:
  - state=IDLE, pe_phase=0, pe_a=pe_b=0
  - acc=0, term count=0, last flag=0
  - out_valid=0, out_data=0, out_count=0
  - in_ready=1 one cycle after rst deasserts, combinationally from state.
- States:
  - IDLE: in_ready=1. A handshake registers pe_a/pe_b/last flag → P1.
  - P1: pe_phase=1 → P2.
  - P2: pe_phase=2 → P3.
  - P3: pe_phase=3; PE registers C_out on this edge → CAP.
  - CAP: pe_phase=0.
    - acc_next = acc + sign_extend(pe_c_out); count_next = count+1.
    - If last flag: out_data=acc_next, out_count=count_next, out_valid=1; clear acc/count → OUT.
    - Else in_ready=1. If a handshake occurs, load new pair → P1; otherwise → IDLE (acc retained).
  - OUT: in_ready=0, pe_phase=0. Hold out_data/out_count stable while out_valid&!out_ready. On out_ready, out_valid=0 → IDLE.
- pe_a/pe_b stay constant from P1 through CAP.
- pe_phase follows the state exactly, with no skipped or repeated phase.
- Latency: handshake at edge t → phase 1 at t+1, 2 at t+2, 3 at t+3, product added at edge t+4. Result valid at t+4 for a last term.
- Throughput: back-to-back accept in CAP gives 4 cycles per term. Phase 0 lasts exactly one cycle between terms.
- Arithmetic: product is sign-extended 2*DATA_WIDTH→ACC_WIDTH. Sum wraps modulo 2^ACC_WIDTH; count wraps modulo 2^CNT_WIDTH.
- in_valid outside IDLE/CAP is ignored and not consumed.
- in_a/in_b are sampled only at the handshake. Later changes have no effect on the term in flight.
- Reset mid-operation discards the partial sum and term count. pe_phase=0 immediately. out_valid stays 0 until the next complete dot product.
- A last term arriving while in IDLE with acc≠0 finishes the running sum.

Decomposition:
- Shared package (pe_seq_pkg): state encoding (IDLE, P1, P2, P3, CAP, OUT) and phase constants PH_IDLE=0, PH_LL=1, PH_LH=2, PH_HL=3.
- One natural sub-module: pe_seq_acc, the accumulator, term counter and output register with hold-on-backpressure. FSM stays in the top.

Test Plan:
- Single term 3×5, in_last=1, out_ready=1 → pe_phase 1,2,3 on consecutive cycles; out_data=15, out_count=1 at t+4.
- Single term (−7)×9 → out_data=−63 (0xFFFFC1); (−128)×(−128) → 16384.
- Back-to-back terms (10,10), (−20,3), (127,127 last) with in_valid held → accepts every 4 cycles; out_data=16169, out_count=3.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_data/out_count stable, in_ready=0, pe_phase=0; release → out_valid drops next edge, then in_ready=1.
- Reset asserted during P2 of the second term of (4,4),(5,5 last) → pe_phase=0 at once, no out_valid. New single term 2×2 last → out_data=4, out_count=1.
- Gap: term (6,7) without last, idle 3 cycles, then (1,1 last) → out_data=43, out_count=2.
